// File: rtl/ama_riscv_fetch_pkg.sv
// Shared defines for the fetch slice.
// Holds the core bus widths, the speculation status struct, the fetch FSM
// state encoding and the instruction-queue entry layout.
package ama_riscv_fetch_pkg;

  localparam int CORE_BYTE_ADDR_BUS = 32;
  localparam int CORE_WORD_ADDR_BUS = 30;

  // Speculation status from the back end; wrong is the flush strobe
  typedef struct packed {
    logic wrong;
  } spec_exec_t;

  // Fetch FSM states, kept as plain constants for legacy tools
  typedef logic [1:0] fe_state_t;
  localparam fe_state_t FE_RESET = 2'd0;
  localparam fe_state_t FE_RUN   = 2'd1;
  localparam fe_state_t FE_FLUSH = 2'd2;

  // One instruction-queue slot: byte PC plus the fetched word
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } iq_entry_t;

endpackage

// File: rtl/ama_riscv_fetch_if.sv
// Ready/valid channel used for the icache request and response paths.
// Ports (per modport):
//   TX : drives valid/data, receives ready
//   RX : receives valid/data, drives ready
interface rv_if #(
  parameter int W = 32
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport TX (output valid, output data, input ready);
  modport RX (input valid, input data, output ready);
endinterface

// File: rtl/ama_riscv_fifo.sv
// Small synchronous FIFO with a flush input, used for both the
// instruction queue and the in-flight PC FIFO.
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   flush       : empties the FIFO this cycle (wins over push/pop)
//   push, din   : write into the tail
//   pop, dout   : read the head (dout is the current head, no latency)
//   count       : current number of valid entries
// A push is accepted on a full FIFO when a pop happens in the same cycle.
module ama_riscv_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 32,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (cnt_q != '0);
    do_push  = push && ((cnt_q != CW'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
    mem_q <= mem_d;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/ama_riscv_fetch.sv
// Instruction fetch front end: issues word-address requests to the icache,
// queues returned instructions with their PCs and presents them to decode.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   spec            : speculation status, spec.wrong flushes and redirects
//   redirect_pc     : new fetch byte address (low two bits ignored)
//   req_icache      : request channel, data = fetch word address
//   rsp_icache      : in-order instruction response channel
//   dec_valid/ready : decode handshake
//   dec_pc/dec_inst : PC and instruction at the head of the queue
module ama_riscv_fetch
  import ama_riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          IQ_DEPTH     = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  spec_exec_t                    spec,
  input  logic [CORE_BYTE_ADDR_BUS-1:0] redirect_pc,
  rv_if.TX                              req_icache,
  rv_if.RX                              rsp_icache,
  output logic                          dec_valid,
  input  logic                          dec_ready,
  output logic [CORE_BYTE_ADDR_BUS-1:0] dec_pc,
  output logic [31:0]                   dec_inst
);

  localparam int CW  = $clog2(IQ_DEPTH + 1);
  localparam int CW1 = CW + 1;

  fe_state_t   state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic        running, flush_now, issue, req_fire;
  logic        rsp_fire, rsp_take, iq_push, dec_fire;
  logic [CW-1:0] iq_cnt, pc_cnt;
  logic [31:0] pc_head;
  iq_entry_t   iq_din, iq_dout;

  always_comb begin
    running   = !rst && (state_q != FE_RESET);
    flush_now = running && spec.wrong;
    // Issue only when every in-flight request is guaranteed a queue slot
    issue     = running && (state_q == FE_RUN) && !spec.wrong &&
                (({1'b0, outstanding_q} + {1'b0, iq_cnt}) < CW1'(IQ_DEPTH)) &&
                (pc_cnt != CW'(IQ_DEPTH));
    req_fire  = issue && req_icache.ready;
    rsp_fire  = rsp_icache.valid && rsp_icache.ready;
    // A response with nothing outstanding belongs to a request abandoned
    // by reset and is swallowed without touching any counter
    rsp_take  = rsp_fire && (outstanding_q != '0);
    iq_push   = rsp_take && (state_q == FE_RUN) && !spec.wrong;
    dec_fire  = dec_valid && dec_ready;
    iq_din    = '{pc: pc_head, inst: rsp_icache.data};
  end

  always_comb begin
    state_d       = state_q;
    drop_cnt_d    = drop_cnt_q;
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_take);
    case (state_q)
      FE_RESET: state_d = FE_RUN;
      FE_RUN: begin
        // Everything still in flight becomes stale; skip FLUSH if none is
        if (spec.wrong) begin
          drop_cnt_d = outstanding_q - CW'(rsp_take);
          if (drop_cnt_d != '0) state_d = FE_FLUSH;
        end
      end
      FE_FLUSH: begin
        drop_cnt_d = drop_cnt_q - CW'(rsp_take);
        if (drop_cnt_d == '0) state_d = FE_RUN;
      end
      default: state_d = FE_RESET;
    endcase
    if (flush_now) begin
      fetch_pc_d = redirect_pc & ~32'h3;
    end else if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FE_RESET;
      fetch_pc_q    <= RESET_VECTOR & ~32'h3;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign req_icache.valid = issue;
  assign req_icache.data  = issue ? fetch_pc_q[31:2] : '0;
  assign rsp_icache.ready = running;
  assign dec_valid        = running && !spec.wrong && (iq_cnt != '0);
  assign dec_pc           = iq_dout.pc;
  assign dec_inst         = iq_dout.inst;

  ama_riscv_fifo #(
    .DEPTH (IQ_DEPTH),
    .WIDTH ($bits(iq_entry_t))
  ) u_iq (
    .clk   (clk),
    .rst   (rst),
    .flush (flush_now),
    .push  (iq_push),
    .din   (iq_din),
    .pop   (dec_fire),
    .dout  (iq_dout),
    .count (iq_cnt)
  );

  // PCs of requests in flight, matched to responses in order
  ama_riscv_fifo #(
    .DEPTH (IQ_DEPTH),
    .WIDTH (32)
  ) u_pc_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush_now),
    .push  (req_fire),
    .din   (fetch_pc_q),
    .pop   (rsp_take),
    .dout  (pc_head),
    .count (pc_cnt)
  );

endmodule

// File: tb/tb_ama_riscv_fetch.sv
// Testbench for ama_riscv_fetch: an in-order icache model with random
// latency feeds the DUT while a queue-based reference model predicts the
// request stream and the instructions handed to decode.
module tb_ama_riscv_fetch;
  import ama_riscv_fetch_pkg::*;

  localparam logic [31:0] RV    = 32'h0000_0040;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  spec_exec_t  spec;
  logic [31:0] redirect_pc;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_pc, dec_inst;

  rv_if #(.W(CORE_WORD_ADDR_BUS)) req_if ();
  rv_if #(.W(32))                 rsp_if ();

  always #5 clk = ~clk;

  ama_riscv_fetch #(
    .RESET_VECTOR (RV),
    .IQ_DEPTH     (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .spec        (spec),
    .redirect_pc (redirect_pc),
    .req_icache  (req_if),
    .rsp_icache  (rsp_if),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_pc      (dec_pc),
    .dec_inst    (dec_inst)
  );

  typedef struct {
    logic [29:0] addr;
    bit          stale;
    bit          orphan;
    int          rdy;
  } ic_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          lat_lo = 1, lat_hi = 1;
  bit          phase = 0;
  logic [31:0] fetch_pc;
  logic [31:0] iq_model[$];
  ic_t         icq[$];

  int          since_rst = 0;
  bit          got_first = 0;
  logic [31:0] first_req = '0;
  int          first_gap = -1;
  logic [31:0] dec_log[$];
  bit          got_req = 0, got_dec = 0;
  logic [31:0] post_req = '0, post_dec = '0;
  int          fire_cnt = 0;

  function automatic logic [31:0] inst_of(input logic [29:0] a);
    return {a[15:0], a[15:0] ^ 16'hC3A5};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare DUT outputs against what the reference model predicts
  task automatic checkOutput(input bit r, input bit w);
    int  live, stale;
    bit  exp_valid, exp_dec;
    live  = 0;
    stale = 0;
    foreach (icq[i]) begin
      if (icq[i].stale) stale++;
      else if (!icq[i].orphan) live++;
    end
    if (r || !phase) begin
      check("idle_req_valid", {31'd0, req_if.valid}, 32'd0);
      check("idle_req_data", {2'b00, req_if.data}, 32'd0);
      check("idle_rsp_ready", {31'd0, rsp_if.ready}, 32'd0);
      check("idle_dec_valid", {31'd0, dec_valid}, 32'd0);
    end else begin
      exp_valid = (stale == 0) && !w && ((live + iq_model.size()) < DEPTH);
      check("req_valid", {31'd0, req_if.valid}, {31'd0, exp_valid});
      if (exp_valid) check("req_data", {2'b00, req_if.data}, {2'b00, fetch_pc[31:2]});
      check("rsp_ready", {31'd0, rsp_if.ready}, 32'd1);
      exp_dec = !w && (iq_model.size() > 0);
      check("dec_valid", {31'd0, dec_valid}, {31'd0, exp_dec});
      if (exp_dec) begin
        check("dec_pc", dec_pc, iq_model[0]);
        check("dec_inst", dec_inst, inst_of(iq_model[0][31:2]));
      end
    end
  endtask

  // Advance the reference model by one clock edge
  task automatic updateModel(input bit r, input bit w, input logic [31:0] rd);
    bit  req_f, rsp_f, dec_f;
    ic_t h;
    req_f = req_if.valid && req_if.ready;
    rsp_f = rsp_if.valid && rsp_if.ready;
    dec_f = dec_valid && dec_ready;
    if (req_f) fire_cnt++;
    if (r) begin
      iq_model.delete();
      fetch_pc = RV;
      if (icq.size() > 0) begin
        h = icq[0];
        icq.delete();
        h.orphan = 1;
        h.stale  = 0;
        h.rdy    = 0;
        icq.push_back(h);
      end
      phase     = 0;
      since_rst = 0;
      got_first = 0;
      dec_log.delete();
    end else begin
      if (w) begin
        foreach (icq[i]) if (!icq[i].orphan) icq[i].stale = 1;
        iq_model.delete();
        fetch_pc = rd & ~32'h3;
        got_req  = 0;
        got_dec  = 0;
      end
      if (dec_f) begin
        if (!got_dec) begin post_dec = dec_pc; got_dec = 1; end
        if (dec_log.size() < 3) dec_log.push_back(dec_pc);
        if (iq_model.size() > 0) void'(iq_model.pop_front());
      end
      if (rsp_f && icq.size() > 0) begin
        h = icq.pop_front();
        if (!h.stale && !h.orphan) iq_model.push_back({h.addr, 2'b00});
      end
      if (req_f) begin
        if (!got_first) begin first_req = {2'b00, req_if.data}; first_gap = since_rst; got_first = 1; end
        if (!got_req) begin post_req = {2'b00, req_if.data}; got_req = 1; end
        icq.push_back('{addr: req_if.data, stale: 0, orphan: 0,
                        rdy: cyc + $urandom_range(lat_lo, lat_hi)});
        fetch_pc = fetch_pc + 32'd4;
      end
      phase = 1;
      since_rst++;
    end
  endtask

  // Drive one or more cycles of stimulus, then check and update the model
  task automatic applyStimulus(input bit r, input bit w, input logic [31:0] rd,
                               input bit rq_rdy, input bit dc_rdy, input int n);
    bit w_eff;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      w_eff          = w && !r && phase;
      rst            = r;
      spec.wrong     = w_eff;
      redirect_pc    = rd;
      req_if.ready   = rq_rdy;
      dec_ready      = dc_rdy;
      rsp_if.valid   = (icq.size() > 0) && (icq[0].rdy <= cyc);
      rsp_if.data    = rsp_if.valid ? inst_of(icq[0].addr) : 32'd0;
      #1;
      checkOutput(r, w_eff);
      updateModel(r, w_eff, rd);
      cyc++;
    end
  endtask

  initial begin
    fetch_pc     = RV;
    rst          = 1'b1;
    spec.wrong   = 1'b0;
    redirect_pc  = '0;
    req_if.ready = 1'b1;
    rsp_if.valid = 1'b0;
    rsp_if.data  = '0;
    dec_ready    = 1'b1;

    // Reset, then an always-hitting icache
    applyStimulus(1, 0, 0, 1, 1, 3);
    applyStimulus(0, 0, 0, 1, 1, 12);
    check("first_req_data", first_req, 32'h10);
    check("first_req_gap", first_gap, 32'd1);
    check("dec_log_size", dec_log.size(), 32'd3);
    if (dec_log.size() == 3) begin
      check("dec_pc0", dec_log[0], 32'h40);
      check("dec_pc1", dec_log[1], 32'h44);
      check("dec_pc2", dec_log[2], 32'h48);
    end

    // Decode stalled: the queue budget caps issue
    fire_cnt = 0;
    applyStimulus(0, 0, 0, 1, 0, 10);
    check("stall_issue_bound", {31'd0, fire_cnt <= DEPTH}, 32'd1);
    applyStimulus(0, 0, 0, 1, 1, 6);

    // Icache miss: request held for 5 cycles
    applyStimulus(0, 0, 0, 0, 1, 5);
    applyStimulus(0, 0, 0, 1, 1, 6);

    // Redirect with two requests in flight
    lat_lo = 4; lat_hi = 4;
    applyStimulus(0, 0, 0, 1, 1, 3);
    applyStimulus(0, 1, 32'h200, 1, 1, 1);
    applyStimulus(0, 0, 0, 1, 1, 12);
    check("redir_req_data", post_req, 32'h80);
    check("redir_dec_pc", post_dec, 32'h200);

    // Two redirects back to back, the second while draining stale responses
    lat_lo = 2; lat_hi = 2;
    applyStimulus(0, 0, 0, 1, 1, 6);
    applyStimulus(0, 1, 32'h300, 1, 1, 1);
    applyStimulus(0, 1, 32'h405, 1, 1, 1);
    applyStimulus(0, 0, 0, 1, 1, 10);
    check("redir2_req_data", post_req, 32'h101);
    check("redir2_dec_pc", post_dec, 32'h404);

    // Reset with a slow response in flight
    lat_lo = 5; lat_hi = 5;
    applyStimulus(0, 0, 0, 1, 1, 3);
    applyStimulus(1, 0, 0, 1, 1, 1);
    lat_lo = 1; lat_hi = 2;
    applyStimulus(0, 0, 0, 1, 1, 12);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      lat_lo = 1;
      lat_hi = 1 + (i / 150);
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 4,
                    $urandom & 32'h0000_3FFF, $urandom_range(0, 9) < 8,
                    $urandom_range(0, 9) < 7, 1);
    end
    applyStimulus(0, 0, 0, 1, 1, 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ama_riscv_fetch.md
AMA_RISCV_FETCH -- requirements
Module: ama_riscv_fetch

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, byte address of the first fetched instruction.
REQ-002 SHALL have parameter IQ_DEPTH, default 2, instruction queue entries; legal values are powers of 2 from 2 to 8.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port spec  in  spec_exec_t  speculation status; spec.wrong is the flush strobe.
REQ-006 SHALL have port redirect_pc  in  CORE_BYTE_ADDR_BUS  new fetch byte address, sampled when spec.wrong=1.
REQ-007 SHALL have port req_icache  rv_if.TX  CORE_WORD_ADDR_BUS  word-address fetch request to the icache.
REQ-008 SHALL have port rsp_icache  rv_if.RX  32  instruction returned by the icache, in request order.
REQ-009 SHALL have port dec_valid  out  1  a queued instruction is presented to decode.
REQ-010 SHALL have port dec_ready  in  1  decode accepts the presented instruction.
REQ-011 SHALL have port dec_pc  out  CORE_BYTE_ADDR_BUS  byte PC of the presented instruction.
REQ-012 SHALL have port dec_inst  out  32  presented instruction word.

Function
REQ-013 SHALL implement states FE_RESET, FE_RUN and FE_FLUSH; FE_RESET->FE_RUN after one cycle; FE_RUN->FE_FLUSH on spec.wrong while stale responses are outstanding; FE_FLUSH->FE_RUN when the drop counter reaches 0.
REQ-014 SHALL issue a request (req_icache.valid=1, data=fetch_pc>>2) in FE_RUN when outstanding+occupancy < IQ_DEPTH and spec.wrong=0.
REQ-015 SHALL count a request as issued only when req_icache.valid && req_icache.ready; fetch_pc then advances by 4.
REQ-016 SHALL keep the outstanding counter in range 0..IQ_DEPTH: +1 on issue, -1 on rsp_icache.valid, net 0 when both occur in the same cycle.
REQ-017 SHALL drive rsp_icache.ready=1 in every state except FE_RESET.
REQ-018 SHALL write each non-stale response into the IQ tail together with its PC, taken from a PC FIFO that is pushed on issue and popped on response.
REQ-019 SHALL present the IQ head on dec_* in the same cycle it becomes valid, with no bypass from rsp_icache to dec_*; dec_* SHALL hold stable while dec_valid && !dec_ready.
REQ-020 SHALL allow a push and a pop in the same cycle when the IQ is full; IQ pointers SHALL wrap modulo IQ_DEPTH.
REQ-021 SHALL, when spec.wrong=1, in the same cycle: empty the IQ and PC FIFO, drive dec_valid=0, load fetch_pc=redirect_pc, and set drop_cnt = outstanding minus any response arriving that cycle.
REQ-022 SHALL, in FE_FLUSH, issue no requests and discard each arriving response while decrementing drop_cnt; the first request to redirect_pc SHALL issue in the cycle after drop_cnt reaches 0.
REQ-023 SHALL let a spec.wrong received in FE_FLUSH reload fetch_pc and keep the current drop_cnt.
REQ-024 SHALL ignore the low two bits of redirect_pc.

Reset
REQ-025 SHALL, on rst, set state=FE_RESET, fetch_pc=RESET_VECTOR, outstanding=0, drop_cnt=0, IQ and PC FIFO empty.
REQ-026 SHALL hold req_icache.valid=0, dec_valid=0, rsp_icache.ready=0 and req_icache.data=0 during reset and in FE_RESET.
REQ-027 SHALL abandon all in-flight requests when rst is asserted mid-operation, with no stale response reaching the IQ afterwards.

Structure
REQ-028 SHALL place the fetch state enum and the IQ entry struct (pc, inst) in the shared defines package beside spec_exec_t.
REQ-029 SHALL instantiate the IQ and the PC FIFO from one sub-module, ama_riscv_fifo (parameters DEPTH, type/width), with sync reset and a flush input.

Verification
REQ-030 SHALL cover: reset with RESET_VECTOR=0x40, icache always hitting -> first req data 0x10 one cycle after FE_RESET; dec_pc sequence 0x40, 0x44, 0x48.
REQ-031 SHALL cover: dec_ready=0 for 10 cycles with IQ_DEPTH=2 -> at most 2 requests issued, no further issue until a pop, dec_* stable throughout.
REQ-032 SHALL cover: an icache miss of 5 cycles -> req_icache.valid held, with one outstanding per entry; responses delivered in PC order with no gaps.
REQ-033 SHALL cover: spec.wrong with redirect_pc=0x200 while 2 requests are outstanding -> both responses dropped, dec_valid=0; next request data 0x80; first dec_pc=0x200.
REQ-034 SHALL cover: spec.wrong in the same cycle as a response and a dec pop, then a second spec.wrong in FE_FLUSH -> drop_cnt is correct and fetch resumes at the second target.
REQ-035 SHALL cover: rst asserted with a miss in flight -> all outputs reach reset values next cycle and the late response is ignored.
